// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves execute-stage control-flow instructions,
// produces the registered outcome / redirect PC, maintains a 2-bit
// bimodal branch history table and a saturating mispredict counter.
//
// Ports:
//   clk_in, rst_in          clock, async active-high reset
//   fetch_pc_in             fetch PC to predict
//   predict_taken_out       combinational prediction for fetch_pc_in
//   ex_*_in                 execute-stage instruction, operands, decode bits
//   resolve_valid_out       registered ex_valid_in
//   branch_taken_out        registered actual outcome
//   mispredict_out          registered outcome != carried prediction
//   redirect_pc_out         registered correct next PC
//   mispredict_count_out    saturating count of mispredicts
module branch_resolve_unit #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 16
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [XLEN-1:0] fetch_pc_in,
  output logic            predict_taken_out,
  input  logic            ex_valid_in,
  input  logic [XLEN-1:0] ex_pc_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [4:0]      opcode_6_to_2_in,
  input  logic [2:0]      funct3_in,
  input  logic            ex_predicted_in,
  output logic            resolve_valid_out,
  output logic            branch_taken_out,
  output logic            mispredict_out,
  output logic [XLEN-1:0] redirect_pc_out,
  output logic [15:0]     mispredict_count_out
);

  localparam int unsigned IDX   = $clog2(BHT_DEPTH);
  localparam int unsigned CNT_W = 16;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [1:0]       bht_d [BHT_DEPTH];
  logic             resolve_valid_q, resolve_valid_d;
  logic             branch_taken_q, branch_taken_d;
  logic             mispredict_q, mispredict_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

  logic [IDX-1:0]   fetch_idx;
  logic [IDX-1:0]   ex_idx;
  logic             is_cond, cond_known, taken, mispredict;
  logic [XLEN-1:0]  pc_target, jalr_sum, target;
  logic             unused_fetch_bits;

  // Only the word-index bits of the fetch PC select a table entry.
  assign fetch_idx         = fetch_pc_in[IDX+1:2];
  assign ex_idx            = ex_pc_in[IDX+1:2];
  assign unused_fetch_bits = ^fetch_pc_in;

  // Prediction reads the registered table; same-edge updates are not forwarded.
  assign predict_taken_out = bht_q[fetch_idx][1];

  // Outcome, target and next-state computation.
  always_comb begin
    is_cond    = (opcode_6_to_2_in == OP_BRANCH);
    cond_known = is_cond && (funct3_in != 3'b010) && (funct3_in != 3'b011);
    taken      = 1'b0;
    if (is_cond) begin
      unique case (funct3_in)
        3'b000:  taken = (rs1_in == rs2_in);
        3'b001:  taken = (rs1_in != rs2_in);
        3'b100:  taken = ($signed(rs1_in) <  $signed(rs2_in));
        3'b101:  taken = ($signed(rs1_in) >= $signed(rs2_in));
        3'b110:  taken = (rs1_in <  rs2_in);
        3'b111:  taken = (rs1_in >= rs2_in);
        default: taken = 1'b0;
      endcase
    end else if ((opcode_6_to_2_in == OP_JAL) || (opcode_6_to_2_in == OP_JALR)) begin
      taken = 1'b1;
    end

    pc_target = ex_pc_in + imm_in;
    jalr_sum  = rs1_in + imm_in;
    target    = (opcode_6_to_2_in == OP_JALR) ? {jalr_sum[XLEN-1:1], 1'b0} : pc_target;
    mispredict = taken ^ ex_predicted_in;

    resolve_valid_d    = ex_valid_in;
    branch_taken_d     = ex_valid_in & taken;
    mispredict_d       = ex_valid_in & mispredict;
    redirect_pc_d      = redirect_pc_q;
    mispredict_count_d = mispredict_count_q;
    bht_d              = bht_q;

    if (ex_valid_in) begin
      redirect_pc_d = taken ? target : (ex_pc_in + XLEN'(4));
      if (mispredict && (mispredict_count_q != {CNT_W{1'b1}})) begin
        mispredict_count_d = mispredict_count_q + CNT_W'(1);
      end
      // Saturating 2-bit counter update for resolvable conditional branches.
      if (cond_known) begin
        if (taken) begin
          if (bht_q[ex_idx] != 2'b11) bht_d[ex_idx] = bht_q[ex_idx] + 2'd1;
        end else begin
          if (bht_q[ex_idx] != 2'b00) bht_d[ex_idx] = bht_q[ex_idx] - 2'd1;
        end
      end
    end
  end

  // State registers; reset returns every predictor entry to weak-not-taken.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(BHT_DEPTH); i++) bht_q[i] <= 2'b01;
      resolve_valid_q    <= 1'b0;
      branch_taken_q     <= 1'b0;
      mispredict_q       <= 1'b0;
      redirect_pc_q      <= '0;
      mispredict_count_q <= '0;
    end else begin
      bht_q              <= bht_d;
      resolve_valid_q    <= resolve_valid_d;
      branch_taken_q     <= branch_taken_d;
      mispredict_q       <= mispredict_d;
      redirect_pc_q      <= redirect_pc_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign resolve_valid_out    = resolve_valid_q;
  assign branch_taken_out     = branch_taken_q;
  assign mispredict_out       = mispredict_q;
  assign redirect_pc_out      = redirect_pc_q;
  assign mispredict_count_out = mispredict_count_q;

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter XLEN, default 32: data and PC width in bits.
REQ-002 Parameter BHT_DEPTH, default 16: number of 2-bit predictor entries; power of 2, minimum 2; IDX = log2(BHT_DEPTH).
REQ-003 clk_in  input  1  single clock; all state updates on rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-high.
REQ-005 fetch_pc_in  input  XLEN  fetch-stage PC to predict.
REQ-006 predict_taken_out  output  1  prediction for fetch_pc_in, combinational.
REQ-007 ex_valid_in  input  1  execute-stage instruction present.
REQ-008 ex_pc_in  input  XLEN  PC of execute-stage instruction.
REQ-009 rs1_in, rs2_in  input  XLEN each  operand values.
REQ-010 imm_in  input  XLEN  sign-extended immediate.
REQ-011 opcode_6_to_2_in  input  5  instruction bits [6:2].
REQ-012 funct3_in  input  3  instruction bits [14:12].
REQ-013 ex_predicted_in  input  1  prediction carried with the instruction from fetch.
REQ-014 resolve_valid_out  output  1  registered ex_valid_in.
REQ-015 branch_taken_out  output  1  registered actual outcome.
REQ-016 mispredict_out  output  1  registered outcome != prediction.
REQ-017 redirect_pc_out  output  XLEN  registered correct next PC.
REQ-018 mispredict_count_out  output  16  saturating mispredict counter.

Function
REQ-019 Index = fetch_pc_in[IDX+1:2] for predict, ex_pc_in[IDX+1:2] for update; bits [1:0] ignored.
REQ-020 predict_taken_out = bit 1 of indexed counter; reads pre-edge table contents (same-cycle update to same index not forwarded).
REQ-021 Opcode 11000 (conditional): funct3 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE; 010/011 never taken and no table update.
REQ-022 Opcode 11011 (JAL) and 11001 (JALR): always taken, no table update.
REQ-023 Any other opcode: taken = 0, no table update.
REQ-024 Target: conditional/JAL = ex_pc_in + imm_in; JALR = (rs1_in + imm_in) with bit 0 cleared; all adds modulo 2^XLEN.
REQ-025 redirect_pc_out = target if taken, else ex_pc_in + 4 (modulo 2^XLEN).
REQ-026 Latency: ex_valid_in sampled at edge N -> resolve_valid_out, branch_taken_out, mispredict_out, redirect_pc_out valid after edge N (1 cycle).
REQ-027 mispredict = taken XOR ex_predicted_in, for all opcodes when ex_valid_in = 1.
REQ-028 When ex_valid_in = 0 at an edge: resolve_valid_out, branch_taken_out, mispredict_out register 0; redirect_pc_out holds; no table or counter update.
REQ-029 Table update (valid conditional, funct3 not 010/011): taken -> counter+1 saturating at 11; not taken -> counter-1 saturating at 00.
REQ-030 Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-031 mispredict_count_out increments by 1 on each edge registering mispredict = 1; holds at 16'hFFFF.
REQ-032 Operands and control inputs are sampled only at the edge; no combinational path from ex inputs to outputs.

Reset
REQ-033 rst_in high immediately forces: all BHT entries 01, resolve_valid_out 0, branch_taken_out 0, mispredict_out 0, redirect_pc_out 0, mispredict_count_out 0.
REQ-034 Reset asserted mid-operation discards the in-flight resolution; first update occurs at the first edge with rst_in low.
REQ-035 predict_taken_out = 0 for every index while in reset.

Verification
REQ-036 BEQ rs1=5, rs2=5, pc=0x100, imm=0x20, predicted 0 -> next cycle taken 1, mispredict 1, redirect 0x120, count 1, entry[0] -> 10.
REQ-037 BLT rs1=0xFFFFFFFF, rs2=1 -> taken 1; BLTU same operands -> taken 0, redirect pc+4.
REQ-038 JALR rs1=0x1003, imm=0x4, predicted 1 -> taken 1, mispredict 0, redirect 0x1006, BHT unchanged.
REQ-039 Three taken BNE at pc=0x40 -> entry[0] 01->10->11->11; predict_taken_out for fetch_pc 0x40 reads 1 from the edge after the first update; same-cycle fetch of 0x40 returns old value.
REQ-040 Force 65536 mispredicts -> count 0xFFFF and holds on further mispredicts; assert rst_in mid-stream -> all outputs 0 and BHT 01 asynchronously, before next edge.
REQ-041 funct3 010 with opcode 11000, predicted 1 -> taken 0, mispredict 1, BHT unchanged; ex_valid_in 0 -> resolve_valid_out 0, count unchanged.
